// File: rtl/control_pkg.sv
// control_pkg: shared constants for the registered ID-stage control unit.
// Opcode/funct encodings, ALU op codes, control-word bit positions and the
// FSM state encoding. ST_TRAP exists only when PIPELINED_CONTROL_ILLEGAL_TRAP_EN
// is defined.
package control_pkg;

  // Width of the decoded control word produced by control_decode.
  localparam int DEC_W = 16;

  // Width of the MUL occupancy counter (holds up to MUL_LATENCY-1 = 15).
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_RTYPE = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b110010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_MUL = 4'd5
  } alu_op_e;

  // Control-word bit positions.
  localparam int CB_REG_WRITE  = 0;
  localparam int CB_MEM_READ   = 1;
  localparam int CB_MEM_WRITE  = 2;
  localparam int CB_MEM_TO_REG = 3;
  localparam int CB_ALU_SRC    = 4;
  localparam int CB_REG_DST    = 5;
  localparam int CB_BRANCH     = 6;
  localparam int CB_JUMP       = 7;
  localparam int CB_ALU_LO     = 8;
  localparam int CB_ALU_HI     = 11;
  localparam int CB_MUL_START  = 12;
  localparam int CB_ILLEGAL    = 13;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1
`ifdef PIPELINED_CONTROL_ILLEGAL_TRAP_EN
    ,
    ST_TRAP     = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/pipelined_control_if.sv
// pipelined_control_if: fetch-side handshake plus the registered decode
// outputs handed to the ID/EX register. The control unit is the slave.
interface pipelined_control_if #(
  parameter int CTRL_W = 16
) ();

  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic              stall;
  logic              ctrl_valid;
  logic [CTRL_W-1:0] ctrl;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;

  modport master (
    output instr_valid, instr,
    input  instr_ready, stall, ctrl_valid, ctrl, rs, rt, rd, imm
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, stall, ctrl_valid, ctrl, rs, rt, rd, imm
  );

endinterface

// File: rtl/control_decode.sv
// control_decode: purely combinational opcode/funct to 16-bit control word,
// plus flags telling the hazard logic which source fields are really read.
module control_decode
  import control_pkg::*;
(
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [DEC_W-1:0] ctrl,
  output logic             uses_rs,
  output logic             uses_rt
);

  // Translate the instruction class into control bits and source-use flags.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl    = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
        ctrl[CB_REG_WRITE] = 1'b1;
        ctrl[CB_REG_DST]   = 1'b1;
        case (funct)
          FN_ADD: ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_ADD;
          FN_SUB: ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_SUB;
          FN_AND: ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_AND;
          FN_OR:  ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_OR;
          FN_SLT: ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_SLT;
          FN_MUL: begin
            ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_MUL;
            ctrl[CB_MUL_START]        = 1'b1;
          end
          default: begin
            // Unknown funct: only the illegal flag, no register reads.
            ctrl             = '0;
            ctrl[CB_ILLEGAL] = 1'b1;
            uses_rs          = 1'b0;
            uses_rt          = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        uses_rs             = 1'b1;
        ctrl[CB_REG_WRITE]  = 1'b1;
        ctrl[CB_MEM_READ]   = 1'b1;
        ctrl[CB_MEM_TO_REG] = 1'b1;
        ctrl[CB_ALU_SRC]    = 1'b1;
      end
      OP_SW: begin
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
        ctrl[CB_MEM_WRITE] = 1'b1;
        ctrl[CB_ALU_SRC]   = 1'b1;
      end
      OP_ADDI: begin
        uses_rs            = 1'b1;
        ctrl[CB_REG_WRITE] = 1'b1;
        ctrl[CB_ALU_SRC]   = 1'b1;
      end
      OP_BEQ: begin
        uses_rs                   = 1'b1;
        uses_rt                   = 1'b1;
        ctrl[CB_BRANCH]           = 1'b1;
        ctrl[CB_ALU_HI:CB_ALU_LO] = ALU_SUB;
      end
      OP_J:    ctrl[CB_JUMP] = 1'b1;
      OP_NOP:  ;
      default: ctrl[CB_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control.sv
// pipelined_control: registered ID-stage control unit. Decodes one accepted
// instruction per cycle with one cycle of latency, stalls on load-use
// hazards, blocks issue while a multi-cycle MUL occupies the multiplier and
// honours a synchronous flush. Defining PIPELINED_CONTROL_ILLEGAL_TRAP_EN adds
// a TRAP state entered after an illegal instruction issues.
module pipelined_control
  import control_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CTRL_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd,
  pipelined_control_if.slave bus
);

  logic [DEC_W-1:0] dec_ctrl;
  logic [DEC_W-1:0] issue_ctrl;
  logic             uses_rs;
  logic             uses_rt;
  logic [4:0]       f_rs;
  logic [4:0]       f_rt;
  logic [4:0]       f_rd;
  logic             hazard;
  logic             ready;
  logic             accept;
  logic             is_mul;
  logic             is_illegal;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic [DEC_W-1:0] ctrl_q, ctrl_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic [4:0]       rd_q, rd_d;
  logic [15:0]      imm_q, imm_d;

  control_decode u_decode (
    .opcode  (bus.instr[31:26]),
    .funct   (bus.instr[5:0]),
    .ctrl    (dec_ctrl),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt)
  );

  assign f_rs       = bus.instr[25:21];
  assign f_rt       = bus.instr[20:16];
  // I-type writers (LW, ADDI) target rt; everything else carries instr[15:11].
  assign f_rd       = (dec_ctrl[CB_REG_WRITE] && !dec_ctrl[CB_REG_DST]) ? f_rt : bus.instr[15:11];
  assign is_mul     = dec_ctrl[CB_MUL_START];
  assign is_illegal = dec_ctrl[CB_ILLEGAL];

`ifdef PIPELINED_CONTROL_ILLEGAL_TRAP_EN
  assign issue_ctrl = dec_ctrl;
`else
  // Without the trap an illegal word issues as a plain NOP.
  assign issue_ctrl = is_illegal ? '0 : dec_ctrl;
`endif

  // Load-use: the load in EX writes a register this instruction reads.
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((uses_rs && (ex_rd == f_rs)) || (uses_rt && (ex_rd == f_rt)));

  assign ready  = (state_q == ST_RUN) && !hazard && !flush;
  assign accept = bus.instr_valid && ready;

  // Next-state logic: flush wins, then MUL occupancy and optional trap entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (is_mul && (MUL_LATENCY > 1)) begin
              state_d = ST_MUL_WAIT;
              cnt_d   = CNT_W'(MUL_LATENCY - 1);
            end
`ifdef PIPELINED_CONTROL_ILLEGAL_TRAP_EN
            else if (is_illegal) begin
              state_d = ST_TRAP;
            end
`endif
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register inputs: load on accept, otherwise issue a bubble.
  always_comb begin
    ctrl_valid_d = accept;
    ctrl_d       = accept ? issue_ctrl : ctrl_q;
    rs_d         = accept ? f_rs : rs_q;
    rt_d         = accept ? f_rt : rt_q;
    rd_d         = accept ? f_rd : rd_q;
    imm_d        = accept ? bus.instr[15:0] : imm_q;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every output register is reset so downstream never sees X fields.
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_q       <= ctrl_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.stall       = bus.instr_valid && !ready;
  assign bus.ctrl_valid  = ctrl_valid_q;
  assign bus.ctrl        = CTRL_W'(ctrl_q);
  assign bus.rs          = rs_q;
  assign bus.rt          = rt_q;
  assign bus.rd          = rd_q;
  assign bus.imm         = imm_q;

endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: directed bench for pipelined_control. Two instances
// share the same stimulus: one with MUL_LATENCY = 4, one with MUL_LATENCY = 1.
// Inputs change 1 time unit after the rising edge; registered outputs are
// sampled there and combinational outputs 1 unit later.
module tb_pipelined_control;

  localparam logic [31:0] I_ADD  = 32'h04644820;  // add r9, r3, r4
  localparam logic [31:0] I_SUB  = 32'h05095022;  // sub r10, r8, r9
  localparam logic [31:0] I_MUL  = 32'h04224032;  // mul r8, r1, r2
  localparam logic [31:0] I_SW   = 32'h0CCA0000;  // sw r10, 0(r6)
  localparam logic [31:0] I_LW   = 32'h086A0000;  // lw r10, 0(r3)
  localparam logic [31:0] I_ADDI = 32'h10051234;  // addi r5, r0, 0x1234

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;

  int n_chk;
  int n_pass;

  pipelined_control_if #(.CTRL_W(16)) bus4 ();
  pipelined_control_if #(.CTRL_W(16)) bus1 ();

  assign bus4.instr_valid = instr_valid;
  assign bus4.instr       = instr;
  assign bus1.instr_valid = instr_valid;
  assign bus1.instr       = instr;

  pipelined_control #(.MUL_LATENCY(4), .CTRL_W(16)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .bus         (bus4)
  );

  pipelined_control #(.MUL_LATENCY(1), .CTRL_W(16)) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .bus         (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (bus4.ctrl_valid !== 1'b0) $display("FAIL rst_valid4: got %b exp 0", bus4.ctrl_valid); else n_pass++;
    n_chk++; if (bus4.ctrl !== 16'h0000) $display("FAIL rst_ctrl4: got %h exp 0000", bus4.ctrl); else n_pass++;
    n_chk++; if (bus4.rd !== 5'd0 || bus4.imm !== 16'h0000) $display("FAIL rst_fields4: got rd %0d imm %h exp 0", bus4.rd, bus4.imm); else n_pass++;
    n_chk++; if (bus1.ctrl_valid !== 1'b0) $display("FAIL rst_valid1: got %b exp 0", bus1.ctrl_valid); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", bus4.instr_ready); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back;
    instr_valid = 1'b1;
    instr       = I_ADD;
    #1;
    n_chk++; if (bus1.instr_ready !== 1'b1) $display("FAIL b2b_ready: got %b exp 1", bus1.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus1.ctrl_valid !== 1'b1 || bus1.ctrl !== 16'h0021) $display("FAIL b2b_add: got v%b %h exp v1 0021", bus1.ctrl_valid, bus1.ctrl); else n_pass++;
    n_chk++; if (bus1.rd !== 5'd9) $display("FAIL b2b_add_rd: got %0d exp 9", bus1.rd); else n_pass++;
    n_chk++; if (bus4.ctrl !== 16'h0021) $display("FAIL b2b_add4: got %h exp 0021", bus4.ctrl); else n_pass++;
    instr = I_SUB;
    step();
    n_chk++; if (bus1.ctrl_valid !== 1'b1 || bus1.ctrl !== 16'h0121) $display("FAIL b2b_sub: got v%b %h exp v1 0121", bus1.ctrl_valid, bus1.ctrl); else n_pass++;
    n_chk++; if (bus1.rd !== 5'd10 || bus1.rs !== 5'd8 || bus1.rt !== 5'd9) $display("FAIL b2b_sub_regs: got %0d/%0d/%0d exp 10/8/9", bus1.rd, bus1.rs, bus1.rt); else n_pass++;
    instr_valid = 1'b0;
    step();
    n_chk++; if (bus1.ctrl_valid !== 1'b0) $display("FAIL b2b_once: got %b exp 0", bus1.ctrl_valid); else n_pass++;
  endtask

  task automatic test_decode_table;
    logic [31:0] vec_i [7];
    logic [15:0] vec_c [7];
    vec_i = '{32'h086A0000, 32'h14430000, 32'h18000000, 32'h00000000,
              32'h04221825, 32'h04221824, 32'h0422182A};
    vec_c = '{16'h001B, 16'h0140, 16'h0080, 16'h0000,
              16'h0321, 16'h0221, 16'h0421};
    instr_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      instr = vec_i[i];
      step();
      n_chk++; if (bus4.ctrl_valid !== 1'b1 || bus4.ctrl !== vec_c[i]) $display("FAIL decode_%0d: got v%b %h exp v1 %h", i, bus4.ctrl_valid, bus4.ctrl, vec_c[i]); else n_pass++;
      if (i == 0) begin
        n_chk++; if (bus4.rd !== 5'd10) $display("FAIL decode_lw_rd: got %0d exp 10", bus4.rd); else n_pass++;
      end
    end
    idle(1);
  endtask

  task automatic test_mul_block;
    instr_valid = 1'b1;
    instr       = I_MUL;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b1 || bus4.ctrl !== 16'h1521) $display("FAIL mul_ctrl: got v%b %h exp v1 1521", bus4.ctrl_valid, bus4.ctrl); else n_pass++;
    n_chk++; if (bus4.rd !== 5'd8) $display("FAIL mul_rd: got %0d exp 8", bus4.rd); else n_pass++;
    instr = I_ADD;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (bus4.instr_ready !== 1'b0 || bus4.stall !== 1'b1) $display("FAIL mul_wait_%0d: got rdy %b stall %b exp 0 1", i, bus4.instr_ready, bus4.stall); else n_pass++;
      step();
      n_chk++; if (bus4.ctrl_valid !== 1'b0) $display("FAIL mul_bubble_%0d: got %b exp 0", i, bus4.ctrl_valid); else n_pass++;
    end
    #1;
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL mul_release: got %b exp 1", bus4.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b1 || bus4.ctrl !== 16'h0021) $display("FAIL mul_then_add: got v%b %h exp v1 0021", bus4.ctrl_valid, bus4.ctrl); else n_pass++;
    idle(1);
  endtask

  task automatic test_mul_latency1;
    instr_valid = 1'b1;
    instr       = I_MUL;
    step();
    n_chk++; if (bus1.ctrl !== 16'h1521) $display("FAIL l1_mul_ctrl: got %h exp 1521", bus1.ctrl); else n_pass++;
    instr = I_ADD;
    #1;
    n_chk++; if (bus1.instr_ready !== 1'b1) $display("FAIL l1_ready: got %b exp 1", bus1.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus1.ctrl_valid !== 1'b1 || bus1.ctrl !== 16'h0021) $display("FAIL l1_add: got v%b %h exp v1 0021", bus1.ctrl_valid, bus1.ctrl); else n_pass++;
    idle(5);
  endtask

  task automatic test_hazard;
    ex_mem_read = 1'b1;
    ex_rd       = 5'd6;
    instr       = I_SW;
    instr_valid = 1'b1;
    #1;
    n_chk++; if (bus4.stall !== 1'b1 || bus4.instr_ready !== 1'b0) $display("FAIL hz_rs_stall: got stall %b rdy %b exp 1 0", bus4.stall, bus4.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b0) $display("FAIL hz_bubble: got %b exp 0", bus4.ctrl_valid); else n_pass++;
    ex_mem_read = 1'b0;
    #1;
    n_chk++; if (bus4.stall !== 1'b0) $display("FAIL hz_clear: got %b exp 0", bus4.stall); else n_pass++;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b1 || bus4.ctrl !== 16'h0014) $display("FAIL hz_sw: got v%b %h exp v1 0014", bus4.ctrl_valid, bus4.ctrl); else n_pass++;
    // rt match: SW reads rt, LW does not.
    ex_mem_read = 1'b1;
    ex_rd       = 5'd10;
    #1;
    n_chk++; if (bus4.stall !== 1'b1) $display("FAIL hz_rt_sw: got %b exp 1", bus4.stall); else n_pass++;
    instr = I_LW;
    #1;
    n_chk++; if (bus4.stall !== 1'b0) $display("FAIL hz_rt_lw: got %b exp 0", bus4.stall); else n_pass++;
    idle(1);
    // ex_rd = 0 never hazards even when rs = 0.
    ex_rd       = 5'd0;
    instr       = I_ADDI;
    instr_valid = 1'b1;
    #1;
    n_chk++; if (bus4.stall !== 1'b0 || bus4.instr_ready !== 1'b1) $display("FAIL hz_r0: got stall %b rdy %b exp 0 1", bus4.stall, bus4.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus4.ctrl !== 16'h0011 || bus4.rd !== 5'd5 || bus4.imm !== 16'h1234) $display("FAIL hz_r0_addi: got %h rd %0d imm %h exp 0011 5 1234", bus4.ctrl, bus4.rd, bus4.imm); else n_pass++;
    ex_mem_read = 1'b0;
    idle(1);
  endtask

  task automatic test_flush;
    instr_valid = 1'b1;
    instr       = I_MUL;
    step();
    instr = I_ADD;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_chk++; if (bus4.ctrl_valid !== 1'b0) $display("FAIL fl_bubble: got %b exp 0", bus4.ctrl_valid); else n_pass++;
    #1;
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL fl_run: got %b exp 1", bus4.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b1 || bus4.ctrl !== 16'h0021) $display("FAIL fl_add: got v%b %h exp v1 0021", bus4.ctrl_valid, bus4.ctrl); else n_pass++;
    // Flush in RUN blocks acceptance.
    flush = 1'b1;
    #1;
    n_chk++; if (bus4.instr_ready !== 1'b0) $display("FAIL fl_block: got %b exp 0", bus4.instr_ready); else n_pass++;
    step();
    flush = 1'b0;
    n_chk++; if (bus4.ctrl_valid !== 1'b0) $display("FAIL fl_run_bubble: got %b exp 0", bus4.ctrl_valid); else n_pass++;
    idle(1);
  endtask

  task automatic test_illegal;
    instr_valid = 1'b1;
    instr       = 32'hFC000000;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b1) $display("FAIL ill_valid: got %b exp 1", bus4.ctrl_valid); else n_pass++;
`ifdef PIPELINED_CONTROL_ILLEGAL_TRAP_EN
    n_chk++; if (bus4.ctrl !== 16'h2000) $display("FAIL ill_ctrl: got %h exp 2000", bus4.ctrl); else n_pass++;
    instr = I_ADD;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (bus4.instr_ready !== 1'b0) $display("FAIL ill_trap_%0d: got %b exp 0", i, bus4.instr_ready); else n_pass++;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL ill_exit: got %b exp 1", bus4.instr_ready); else n_pass++;
    idle(1);
    instr_valid = 1'b1;
    instr       = 32'h0400003F;
    step();
    n_chk++; if (bus4.ctrl !== 16'h2000) $display("FAIL ill_funct: got %h exp 2000", bus4.ctrl); else n_pass++;
    flush = 1'b1;
    step();
    flush = 1'b0;
`else
    n_chk++; if (bus4.ctrl !== 16'h0000) $display("FAIL ill_ctrl: got %h exp 0000", bus4.ctrl); else n_pass++;
    instr = 32'h0400003F;
    #1;
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL ill_no_trap: got %b exp 1", bus4.instr_ready); else n_pass++;
    step();
    n_chk++; if (bus4.ctrl_valid !== 1'b1 || bus4.ctrl !== 16'h0000) $display("FAIL ill_funct: got v%b %h exp v1 0000", bus4.ctrl_valid, bus4.ctrl); else n_pass++;
`endif
    idle(1);
  endtask

  task automatic test_reset_mid_mul;
    instr_valid = 1'b1;
    instr       = I_MUL;
    step();
    instr_valid = 1'b0;
    rst_n       = 1'b0;
    #1;
    n_chk++; if (bus4.ctrl_valid !== 1'b0 || bus4.ctrl !== 16'h0000) $display("FAIL rmid_out: got v%b %h exp v0 0000", bus4.ctrl_valid, bus4.ctrl); else n_pass++;
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL rmid_run: got %b exp 1", bus4.instr_ready); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    n_chk++; if (bus4.instr_ready !== 1'b1) $display("FAIL rmid_after: got %b exp 1", bus4.instr_ready); else n_pass++;
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    flush       = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    test_reset();
    test_back_to_back();
    test_decode_table();
    test_mul_block();
    test_mul_latency1();
    test_hazard();
    test_flush();
    test_illegal();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
